// File: rtl/ee201_slowclk_monitor.sv
// ee201_slowclk_monitor
//   Brings a slow square wave (e.g. the 60 Hz divided clock) into the Clk
//   domain. It emits one-cycle rise/fall pulses, measures each rise-to-rise
//   period in Clk cycles, flags whether that period is within tolerance of
//   the expected count, and flags loss of the slow clock.
//
// Ports:
//   Clk          system clock (100 MHz)
//   Reset_n      asynchronous active-low reset
//   ClkIn        slow clock under monitor, asynchronous to Clk
//   RisePulse    one-Clk pulse per detected ClkIn rising edge
//   FallPulse    one-Clk pulse per detected ClkIn falling edge
//   Period       last measured rise-to-rise period in Clk cycles
//   PeriodValid  high while Period holds a measurement from the current lock
//   InRange      high when PeriodValid and |Period - EXPECT_N| <= TOL
//   Lost         high from timeout until the next detected rise
module ee201_slowclk_monitor #(
  parameter int unsigned      WIDTH     = 21,
  parameter logic [WIDTH-1:0] EXPECT_N  = 21'd1666667,
  parameter logic [WIDTH-1:0] TOL       = 21'd16667,
  parameter logic [WIDTH-1:0] TIMEOUT_N = 21'd2000000
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             ClkIn,
  output logic             RisePulse,
  output logic             FallPulse,
  output logic [WIDTH-1:0] Period,
  output logic             PeriodValid,
  output logic             InRange,
  output logic             Lost
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKED
  } state_t;

  state_t           state;
  logic             s1, s2, hist;
  logic             rise, fall;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH:0]   cnt_x, exp_x, diff;
  logic             cnt_in_range;
  logic             at_timeout;

  // Synchronizer, edge history and registered edge pulses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      hist      <= 1'b0;
      RisePulse <= 1'b0;
      FallPulse <= 1'b0;
    end else begin
      s1        <= ClkIn;
      s2        <= s1;
      hist      <= s2;
      RisePulse <= rise;
      FallPulse <= fall;
    end
  end

  assign rise = s2 & ~hist;
  assign fall = ~s2 & hist;

  // Tolerance check one bit wider than the counter so neither subtraction
  // can wrap.
  assign cnt_x        = {1'b0, cnt};
  assign exp_x        = {1'b0, EXPECT_N};
  assign diff         = (cnt_x >= exp_x) ? (cnt_x - exp_x) : (exp_x - cnt_x);
  assign cnt_in_range = (diff <= {1'b0, TOL});

  // Counter restarts at 1 after a rise, so only ARMED/LOCKED can reach the
  // limit from a fresh start; a rise on the same edge takes priority.
  assign at_timeout = (cnt >= TIMEOUT_N);

  // Period counter and lock state machine; Period is sampled from cnt on
  // the same edge RisePulse is registered, so both appear together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cnt         <= ONE;
      Period      <= '0;
      PeriodValid <= 1'b0;
      InRange     <= 1'b0;
      Lost        <= 1'b0;
    end else begin
      if (rise) begin
        cnt  <= ONE;
        Lost <= 1'b0;
      end else if (cnt != '1) begin
        cnt <= cnt + ONE;
      end

      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= ARMED;
          end
        end
        ARMED: begin
          if (rise) begin
            state       <= LOCKED;
            Period      <= cnt;
            PeriodValid <= 1'b1;
            InRange     <= cnt_in_range;
          end else if (at_timeout) begin
            state <= IDLE;
            Lost  <= 1'b1;
          end
        end
        LOCKED: begin
          if (rise) begin
            Period  <= cnt;
            InRange <= cnt_in_range;
          end else if (at_timeout) begin
            state       <= IDLE;
            PeriodValid <= 1'b0;
            InRange     <= 1'b0;
            Lost        <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          PeriodValid <= 1'b0;
          InRange     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ee201_slowclk_monitor.sv
module tb_ee201_slowclk_monitor;

  logic       Clk;
  logic       Reset_n;
  logic       ClkIn;
  logic       RisePulse;
  logic       FallPulse;
  logic [7:0] Period;
  logic       PeriodValid;
  logic       InRange;
  logic       Lost;

  ee201_slowclk_monitor #(
    .WIDTH     (8),
    .EXPECT_N  (8'd20),
    .TOL       (8'd2),
    .TIMEOUT_N (8'd50)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .ClkIn       (ClkIn),
    .RisePulse   (RisePulse),
    .FallPulse   (FallPulse),
    .Period      (Period),
    .PeriodValid (PeriodValid),
    .InRange     (InRange),
    .Lost        (Lost)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Expected state at each RisePulse.
  typedef struct {
    int unsigned period;
    bit          valid;
    bit          inr;
    bit          lost_prev;  // Lost on the sample just before the pulse
    int unsigned falls;      // FallPulses since previous RisePulse / reset
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned falls_since = 0;
  int unsigned fall_total = 0;
  int unsigned rise_total = 0;
  bit          prev_rise = 1'b0;
  bit          prev_fall = 1'b0;
  bit          prev_lost = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per RisePulse.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      falls_since = 0;
      prev_rise   = 1'b0;
      prev_fall   = 1'b0;
      prev_lost   = 1'b0;
    end else begin
      if (FallPulse) begin
        chk("fall_width", prev_fall, 0);
        falls_since++;
        fall_total++;
      end
      if (RisePulse) begin
        rise_total++;
        chk("rise_width", prev_rise, 0);
        chk("rise_expected", (q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("period", Period, e.period);
          chk("period_valid", PeriodValid, e.valid);
          chk("in_range", InRange, e.inr);
          chk("lost_at_rise", Lost, 0);
          chk("lost_before_rise", prev_lost, e.lost_prev);
          chk("falls_between", falls_since, e.falls);
        end
        falls_since = 0;
      end
      prev_rise = RisePulse;
      prev_fall = FallPulse;
      prev_lost = Lost;
    end
  end

  // One ClkIn period starting at a negedge: high for h samples, low for p-h.
  task automatic do_row(input int unsigned p, input int unsigned h,
                        input int unsigned eper, input bit ev, input bit ei,
                        input bit elp, input int unsigned ef);
    exp_t x;
    x.period    = eper;
    x.valid     = ev;
    x.inr       = ei;
    x.lost_prev = elp;
    x.falls     = ef;
    q.push_back(x);
    ClkIn = 1'b1;
    repeat (h) @(negedge Clk);
    ClkIn = 1'b0;
    repeat (p - h) @(negedge Clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0;
    ClkIn   = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_rise", RisePulse, 0);
    chk("reset_fall", FallPulse, 0);
    chk("reset_period", Period, 0);
    chk("reset_valid", PeriodValid, 0);
    chk("reset_inrange", InRange, 0);
    chk("reset_lost", Lost, 0);
    Reset_n = 1'b1;

    // Lock at 20, then tolerance boundaries (+4, +2, -3, -2).
    do_row(20, 10,  0, 0, 0, 0, 0);
    do_row(20, 10, 20, 1, 1, 0, 1);
    do_row(24, 10, 20, 1, 1, 0, 1);
    do_row(22, 10, 24, 1, 0, 0, 1);
    do_row(17, 10, 22, 1, 1, 0, 1);
    do_row(18, 10, 17, 1, 0, 0, 1);
    do_row(20, 10, 18, 1, 1, 0, 1);
    do_row(20, 10, 20, 1, 1, 0, 1);

    // Hold low: Lost exactly 50 cycles after the last detected rise.
    repeat (32) @(negedge Clk);
    chk("pre_timeout_lost", Lost, 0);
    chk("pre_timeout_valid", PeriodValid, 1);
    @(negedge Clk);
    chk("timeout_lost", Lost, 1);
    chk("timeout_valid", PeriodValid, 0);
    chk("timeout_inrange", InRange, 0);
    chk("timeout_period", Period, 20);

    // Recovery: first rise only re-arms and clears Lost.
    do_row(20, 10, 20, 0, 0, 1, 1);
    do_row(20, 10, 20, 1, 1, 0, 1);
    // Rise lands on Cnt==50: rise wins over timeout.
    do_row(50, 10, 20, 1, 1, 0, 1);
    do_row(20, 10, 50, 1, 0, 0, 1);
    do_row(20, 10, 20, 1, 1, 0, 1);

    // Asynchronous reset between edges while locked.
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_reset_period", Period, 0);
    chk("async_reset_valid", PeriodValid, 0);
    chk("async_reset_inrange", InRange, 0);
    chk("async_reset_lost", Lost, 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    do_row(20, 10,  0, 0, 0, 0, 0);
    do_row(20, 10, 20, 1, 1, 0, 1);

    // Single-cycle-wide highs.
    do_row(20, 1, 20, 1, 1, 0, 1);
    do_row(20, 1, 20, 1, 1, 0, 1);
    do_row(20, 1, 20, 1, 1, 0, 1);

    repeat (10) @(negedge Clk);
    chk("queue_drained", q.size(), 0);
    chk("rise_total", rise_total, 18);
    chk("fall_total", fall_total, 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
